// File: rtl/regfile_sequencer_pkg.sv
// Shared definitions for the register-file sequencer: opcodes, instruction
// field positions, FSM state encoding and the default ALU watchdog limit.
package regfile_sequencer_pkg;

  localparam int ALU_TIMEOUT_DEF = 16;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_MOV = 4'h1;
  localparam logic [3:0] OP_LDI = 4'h2;

  localparam int OPC_LO = 12;
  localparam int RD_LO  = 9;
  localparam int RA_LO  = 6;
  localparam int RB_LO  = 3;
  localparam int IMM_LO = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_OPND,
    S_EXEC,
    S_WB,
    S_FIN
  } state_e;

  // Opcodes 0x8-0xF all go to the ALU.
  function automatic logic is_alu_op(input logic [3:0] opc);
    return opc[3];
  endfunction

endpackage

// File: rtl/regfile_sequencer_alu_watchdog.sv
// Down-counter bounding how many EXEC cycles the sequencer waits for alu_done.
module alu_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // Loaded with TIMEOUT-1 so expiry is flagged in the TIMEOUT-th run cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= CW'(TIMEOUT - 1);
    else if (run && cnt != '0)
      cnt <= cnt - CW'(1);
  end

  assign expired = run && (cnt == '0);

endmodule

// File: rtl/regfile_sequencer.sv
// Operand-fetch / execute / write-back controller for the 8x8 register file,
// with an ALU start/done handshake and a watchdog on the ALU.
module regfile_sequencer
  import regfile_sequencer_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 3,
  parameter int ALU_TIMEOUT = ALU_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [ADDR_W-1:0] A_add,
  output logic [ADDR_W-1:0] B_add,
  output logic [ADDR_W-1:0] D_add,
  output logic [DATA_W-1:0] data_in,
  output logic              write_enable,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_start,
  input  logic              alu_done,
  input  logic [DATA_W-1:0] alu_result,
  output logic              done,
  output logic              err
);

  state_e     state, state_d;
  logic       err_d;
  logic       is_alu;
  logic       accept;
  logic       wd_load;
  logic       wd_expired;
  logic [3:0] opc_in;

  assign opc_in      = instr[OPC_LO +: 4];
  assign instr_ready = (state == S_IDLE) && !rst;
  assign accept      = instr_valid && instr_ready;
  assign wd_load     = (state == S_OPND) && (state_d == S_EXEC);

  alu_watchdog #(.TIMEOUT(ALU_TIMEOUT)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .load    (wd_load),
    .run     (state == S_EXEC),
    .expired (wd_expired)
  );

  always_comb begin
    state_d = state;
    err_d   = 1'b0;
    case (state)
      S_IDLE: if (accept) begin
        if (opc_in == OP_NOP)
          state_d = S_FIN;
        else if (opc_in == OP_LDI)
          state_d = S_WB;
        else if (opc_in == OP_MOV || is_alu_op(opc_in))
          state_d = S_READ;
        else begin
          state_d = S_FIN;
          err_d   = 1'b1;
        end
      end
      S_READ: state_d = S_OPND;
      S_OPND: state_d = is_alu ? S_EXEC : S_WB;
      // A done arriving in the expiry cycle still counts as success.
      S_EXEC: if (alu_done)
                state_d = S_WB;
              else if (wd_expired) begin
                state_d = S_FIN;
                err_d   = 1'b1;
              end
      S_WB:   state_d = S_FIN;
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      is_alu       <= 1'b0;
      A_add        <= '0;
      B_add        <= '0;
      D_add        <= '0;
      data_in      <= '0;
      alu_op       <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      write_enable <= 1'b0;
      alu_start    <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= state_d;
      write_enable <= (state_d == S_WB);
      alu_start    <= wd_load;
      done         <= (state_d == S_FIN);
      err          <= (state_d == S_FIN) && err_d;
      if (accept) begin
        is_alu  <= is_alu_op(opc_in);
        A_add   <= instr[RA_LO +: ADDR_W];
        B_add   <= instr[RB_LO +: ADDR_W];
        D_add   <= instr[RD_LO +: ADDR_W];
        alu_op  <= opc_in[2:0];
        data_in <= DATA_W'(instr[IMM_LO +: 8]);
      end
      if (state == S_OPND) begin
        alu_a <= data_a;
        alu_b <= data_b;
        if (!is_alu)
          data_in <= data_a;
      end
      if (state == S_EXEC && alu_done)
        data_in <= alu_result;
    end
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench: register-file and ALU models around the sequencer, a vector
// table for single instructions, plus reset-abort and back-to-back sequences.
module tb_regfile_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = '0;
  logic [2:0]  A_add, B_add, D_add;
  logic [7:0]  data_in;
  logic        write_enable;
  logic [7:0]  data_a = '0, data_b = '0;
  logic [2:0]  alu_op;
  logic [7:0]  alu_a, alu_b;
  logic        alu_start;
  logic        alu_done;
  logic [7:0]  alu_result;
  logic        done, err;

  int checks = 0;
  int errors = 0;

  regfile_sequencer #(.DATA_W(8), .ADDR_W(3), .ALU_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .A_add(A_add), .B_add(B_add), .D_add(D_add),
    .data_in(data_in), .write_enable(write_enable), .data_a(data_a),
    .data_b(data_b), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_start(alu_start), .alu_done(alu_done), .alu_result(alu_result),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Register file: registered reads, write on the rising edge.
  logic [7:0] mem [8] = '{default: 8'h00};
  always @(posedge clk) begin
    if (write_enable) mem[D_add] <= data_in;
    data_a <= mem[A_add];
    data_b <= mem[B_add];
  end

  // Model ALU: done arrives alu_delay cycles after the start cycle.
  int   alu_delay = 0;
  bit   alu_en = 1'b1;
  logic alu_busy = 1'b0;
  int   alu_el = 0;
  assign alu_done = alu_en && ((alu_start && alu_delay == 0) ||
                               (alu_busy && !alu_start && alu_el == alu_delay));
  always_comb begin
    alu_result = alu_a ^ alu_b;
    case (alu_op)
      3'd0: alu_result = alu_a + alu_b;
      3'd1: alu_result = alu_a - alu_b;
      default: alu_result = alu_a ^ alu_b;
    endcase
  end
  always @(posedge clk) begin
    if (rst)            alu_busy <= 1'b0;
    else if (alu_start) begin alu_busy <= (alu_delay != 0); alu_el <= 1; end
    else if (alu_done)  alu_busy <= 1'b0;
    else if (alu_busy)  alu_el <= alu_el + 1;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [15:0] ins;
    int          dly;
    bit          en;
    int          lat;
    bit          e;
    int          wr;
    logic [2:0]  wa;
    logic [7:0]  wd;
    int          st;
    logic [7:0]  aa;
    logic [7:0]  ab;
  } vec_t;

  vec_t vecs [11];

  task automatic run_vec(input vec_t v, input int n);
    int lat, wr, st;
    logic got_done, got_err;
    logic [2:0] wa, op;
    logic [7:0] wd, aa, ab;
    lat = 0; wr = 0; st = 0; got_done = 1'b0; got_err = 1'b0;
    wa = '0; wd = '0; aa = '0; ab = '0; op = '0;
    @(negedge clk);
    chk($sformatf("v%0d ready", n), instr_ready, 1'b1);
    alu_delay = v.dly; alu_en = v.en;
    instr = v.ins; instr_valid = 1'b1;
    @(posedge clk); #1 instr_valid = 1'b0;
    while (!got_done && lat < 100) begin
      @(negedge clk);
      lat++;
      if (lat == 1) chk($sformatf("v%0d busy", n), instr_ready, 1'b0);
      if (write_enable) begin wr++; wa = D_add; wd = data_in; end
      if (alu_start) begin st++; aa = alu_a; ab = alu_b; op = alu_op; end
      if (done) begin got_done = 1'b1; got_err = err; end
    end
    chk($sformatf("v%0d latency", n), lat, v.lat);
    chk($sformatf("v%0d err", n), got_err, v.e);
    chk($sformatf("v%0d writes", n), wr, v.wr);
    if (v.wr != 0) begin
      chk($sformatf("v%0d D_add", n), wa, v.wa);
      chk($sformatf("v%0d data_in", n), wd, v.wd);
    end
    chk($sformatf("v%0d starts", n), st, v.st);
    if (v.st != 0) begin
      chk($sformatf("v%0d alu_a", n), aa, v.aa);
      chk($sformatf("v%0d alu_b", n), ab, v.ab);
      chk($sformatf("v%0d alu_op", n), op, {1'b0, v.ins[13:12]} | {v.ins[14], 2'b00});
    end
  endtask

  initial begin
    logic [15:0] q [3];
    int idx, cyc, dn, bad;
    bit acc;

    //            ins       dly en lat e wr wa  wd     st aa     ab
    vecs[0]  = '{16'h265A, 0, 1, 2,  0, 1, 3, 8'h5A, 0, 8'h00, 8'h00}; // LDI r3,5A
    vecs[1]  = '{16'h12C0, 0, 1, 4,  0, 1, 1, 8'h5A, 0, 8'h00, 8'h00}; // MOV r1<-r3
    vecs[2]  = '{16'h240F, 0, 1, 2,  0, 1, 2, 8'h0F, 0, 8'h00, 8'h00}; // LDI r2,0F
    vecs[3]  = '{16'h28F0, 0, 1, 2,  0, 1, 4, 8'hF0, 0, 8'h00, 8'h00}; // LDI r4,F0
    vecs[4]  = '{16'h8AA0, 0, 1, 5,  0, 1, 5, 8'hFF, 1, 8'h0F, 8'hF0}; // ADD r5,r2,r4
    vecs[5]  = '{16'h8AA0, 3, 1, 8,  0, 1, 5, 8'hFF, 1, 8'h0F, 8'hF0}; // same, delay 3
    vecs[6]  = '{16'h9D10, 1, 1, 6,  0, 1, 6, 8'hE1, 1, 8'hF0, 8'h0F}; // SUB r6,r4,r2
    vecs[7]  = '{16'h5000, 0, 1, 1,  1, 0, 0, 8'h00, 0, 8'h00, 8'h00}; // illegal 0x5
    vecs[8]  = '{16'h0000, 0, 1, 1,  0, 0, 0, 8'h00, 0, 8'h00, 8'h00}; // NOP
    vecs[9]  = '{16'h8EA0, 0, 0, 19, 1, 0, 0, 8'h00, 1, 8'h0F, 8'hF0}; // ADD r7, timeout
    vecs[10] = '{16'h2C11, 0, 1, 2,  0, 1, 6, 8'h11, 0, 8'h00, 8'h00}; // LDI r6,11

    #1 rst = 1'b1;
    #2;
    chk("rst instr_ready", instr_ready, 1'b0);
    chk("rst write_enable", write_enable, 1'b0);
    chk("rst strobes", {alu_start, done, err}, 3'b000);
    chk("rst addrs", {A_add, B_add, D_add}, 9'h000);
    chk("rst data", {data_in, alu_a, alu_b}, 24'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    chk("mem r1", mem[1], 8'h5A);
    chk("mem r5", mem[5], 8'hFF);
    chk("mem r7 timeout", mem[7], 8'h00);
    chk("mem r6 preload", mem[6], 8'h11);

    // Reset during WB of LDI r6,AA: no write, outputs cleared at once.
    @(negedge clk);
    alu_en = 1'b1; alu_delay = 0;
    instr = 16'h2CAA; instr_valid = 1'b1;
    @(posedge clk); #1 instr_valid = 1'b0;
    chk("wb entered", write_enable, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("abort write_enable", write_enable, 1'b0);
    chk("abort outputs", {done, err, D_add, data_in}, 13'h0);
    chk("abort ready", instr_ready, 1'b0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("abort r6", mem[6], 8'h11);
    chk("ready after release", instr_ready, 1'b1);
    dn = 0;
    repeat (4) begin @(negedge clk); if (done) dn++; end
    chk("abort no done", dn, 0);

    // Back-to-back with instr_valid held high: LDI r0,33; MOV r2<-r0; ADD r1,r0,r2.
    q[0] = 16'h2033; q[1] = 16'h1400; q[2] = 16'h8210;
    idx = 0; cyc = 0; dn = 0; bad = 0;
    @(negedge clk);
    instr = q[0]; instr_valid = 1'b1;
    while (dn < 3 && cyc < 200) begin
      if (cyc != 0) @(negedge clk);
      cyc++;
      if (done) dn++;
      if (done && instr_ready) bad++;
      acc = instr_ready && instr_valid;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 3) instr = q[idx];
        else instr_valid = 1'b0;
      end
    end
    instr_valid = 1'b0;
    chk("b2b dones", dn, 3);
    chk("b2b accepts", idx, 3);
    chk("b2b ready in FIN", bad, 0);
    chk("b2b r0", mem[0], 8'h33);
    chk("b2b r2", mem[2], 8'h33);
    chk("b2b r1", mem[1], 8'h66);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
